// File: rtl/instruction_queue_if.sv
// Fetch/issue bundle between instruction_queue (slave) and its environment (master).
// stallCycles exists only when ISSUE_STATS_EN is defined.
interface instruction_queue_if #(parameter int PTR_W = 3);
  logic [15:0]    instIn;
  logic           instInValid;
  logic           instInReady;
  logic           flush;
  logic           disponivelAdd;
  logic           disponivelMul;
  logic [15:0]    instruction;
  logic           Adderin;
  logic           Multin;
  logic [PTR_W:0] count;
  logic           halted;
  logic           illegal;
`ifdef ISSUE_STATS_EN
  logic [15:0]    stallCycles;
`endif

  modport master (
    output instIn, instInValid, flush, disponivelAdd, disponivelMul,
    input  instInReady, instruction, Adderin, Multin, count, halted, illegal
`ifdef ISSUE_STATS_EN
    , input stallCycles
`endif
  );

  modport slave (
    input  instIn, instInValid, flush, disponivelAdd, disponivelMul,
    output instInReady, instruction, Adderin, Multin, count, halted, illegal
`ifdef ISSUE_STATS_EN
    , output stallCycles
`endif
  );
endinterface

// File: rtl/instruction_queue.sv
// In-order FIFO + issue to adder/multiplier RS; strobes one cycle after pop, stalls on !disponivel or hold-off.
// Backpressure: instInReady = !full. Optional ISSUE_STATS_EN adds stallCycles.
module instruction_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic                 Clock,
  input  logic                 Reset,
  instruction_queue_if.slave   bus
);
  typedef enum logic {RUN, HALTED} state_t;

  state_t            state, state_nxt;
  logic [15:0]       mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    cnt;
  logic [15:0]       head, instr_q;
  logic              add_q, mul_q, ill_q;
  logic              full, push, pop;
  logic              issue_add, issue_mul, drop_ill;
  logic              is_add, is_mul, is_halt;
  logic              clr;

  assign clr  = Reset || bus.flush;
  assign head = mem[rd_ptr];
  assign full = (cnt == (PTR_W+1)'(DEPTH));
  assign push = bus.instInValid && !full;

  always_comb begin
    is_add  = 1'b0;
    is_mul  = 1'b0;
    is_halt = 1'b0;
    case (head[3:0])
      4'b0000, 4'b0001, 4'b0100: is_add  = 1'b1;
      4'b0010, 4'b0011:          is_mul  = 1'b1;
      4'b1111:                   is_halt = 1'b1;
      default: ;
    endcase
  end

  // add_q/mul_q double as hold-off: disponivel lags the issue by one cycle.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    issue_add = 1'b0;
    issue_mul = 1'b0;
    drop_ill  = 1'b0;
    if (state == RUN && cnt != '0) begin
      if (is_add) begin
        if (bus.disponivelAdd && !add_q) begin
          pop       = 1'b1;
          issue_add = 1'b1;
        end
      end else if (is_mul) begin
        if (bus.disponivelMul && !mul_q) begin
          pop       = 1'b1;
          issue_mul = 1'b1;
        end
      end else if (is_halt) begin
        pop       = 1'b1;
        state_nxt = HALTED;
      end else begin
        pop      = 1'b1;
        drop_ill = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (clr) state <= RUN;
    else     state <= state_nxt;
  end

  always_ff @(posedge Clock) begin
    if (clr) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      instr_q <= '0;
      add_q   <= 1'b0;
      mul_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
      if (issue_add || issue_mul) instr_q <= head;
      add_q <= issue_add;
      mul_q <= issue_mul;
      ill_q <= drop_ill;
    end
  end

  always_ff @(posedge Clock) begin
    if (push && !clr) mem[wr_ptr] <= bus.instIn;
  end

`ifdef ISSUE_STATS_EN
  logic [15:0] stall_cnt;
  always_ff @(posedge Clock) begin
    if (clr)
      stall_cnt <= '0;
    else if (state == RUN && cnt != '0 && !pop && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 1'b1;
  end
  assign bus.stallCycles = stall_cnt;
`endif

  assign bus.instInReady = !full;
  assign bus.instruction = instr_q;
  assign bus.Adderin     = add_q;
  assign bus.Multin      = mul_q;
  assign bus.count       = cnt;
  assign bus.halted      = (state == HALTED);
  assign bus.illegal     = ill_q;
endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: queue-level reference model checked every cycle plus literal spot checks.
module tb_instruction_queue;
  localparam int DEPTH = 8;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  instruction_queue_if #(.PTR_W(3)) bus ();
  instruction_queue #(.DEPTH(DEPTH), .PTR_W(3)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: an instruction list, halt flag and last-cycle strobes.
  logic [15:0] q[$];
  bit          m_halt;
  logic [15:0] e_ins;
  bit          e_add, e_mul, e_ill;
  int          m_stall;
  bit          push_ok, popped, na, nm, ni;
  logic [15:0] h;

  always @(posedge Clock) begin
    if (Reset || bus.flush) begin
      q.delete();
      m_halt = 0; e_ins = '0; e_add = 0; e_mul = 0; e_ill = 0; m_stall = 0;
    end else begin
      push_ok = bus.instInValid && (q.size() < DEPTH);
      na = 0; nm = 0; ni = 0; popped = 0;
      if (!m_halt && q.size() > 0) begin
        h = q[0];
        case (h[3:0])
          4'h0, 4'h1, 4'h4: if (bus.disponivelAdd && !e_add) begin popped = 1; na = 1; e_ins = h; end
          4'h2, 4'h3:       if (bus.disponivelMul && !e_mul) begin popped = 1; nm = 1; e_ins = h; end
          4'hF:             begin popped = 1; m_halt = 1; end
          default:          begin popped = 1; ni = 1; end
        endcase
        if (popped) void'(q.pop_front());
        else if (m_stall < 16'hFFFF) m_stall++;
      end
      if (push_ok) q.push_back(bus.instIn);
      e_add = na; e_mul = nm; e_ill = ni;
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      chk("instruction", bus.instruction, e_ins);
      chk("Adderin", bus.Adderin, e_add);
      chk("Multin", bus.Multin, e_mul);
      chk("illegal", bus.illegal, e_ill);
      chk("halted", bus.halted, m_halt);
      chk("count", bus.count, q.size());
      chk("instInReady", bus.instInReady, q.size() < DEPTH);
      chk("strobe_excl", bus.Adderin && bus.Multin, 0);
`ifdef ISSUE_STATS_EN
      chk("stallCycles", bus.stallCycles, m_stall);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  logic [15:0] got[$];
  logic [15:0] exp_w;

  initial begin
    Reset = 1'b1;
    bus.instIn = '0; bus.instInValid = 0; bus.flush = 0;
    bus.disponivelAdd = 0; bus.disponivelMul = 0;
    cyc(2);
    chk_en = 1'b1;
    chk("rst_count", bus.count, 0);
    chk("rst_ready", bus.instInReady, 1);
    chk("rst_instr", bus.instruction, 16'h0000);
    chk("rst_halted", bus.halted, 0);
    Reset = 1'b0;
    cyc(1);

    // single add: strobe two cycles after the push
    bus.disponivelAdd = 1; bus.instIn = 16'h0C80; bus.instInValid = 1;
    cyc(1);
    bus.instInValid = 0;
    chk("t1_count1", bus.count, 1);
    cyc(1);
    chk("t1_adderin", bus.Adderin, 1);
    chk("t1_instr", bus.instruction, 16'h0C80);
    chk("t1_count0", bus.count, 0);
    cyc(1);
    chk("t1_adderin_off", bus.Adderin, 0);

    // back-to-back adds: N, N+2
    bus.instIn = 16'h0A91; bus.instInValid = 1;
    cyc(1);
    bus.instIn = 16'h0524;
    cyc(1);
    bus.instInValid = 0;
    chk("t2_N", bus.Adderin, 1);
    chk("t2_N_instr", bus.instruction, 16'h0A91);
    cyc(1);
    chk("t2_N1", bus.Adderin, 0);
    cyc(1);
    chk("t2_N2", bus.Adderin, 1);
    chk("t2_N2_instr", bus.instruction, 16'h0524);
    cyc(1);

    // add then mul on consecutive cycles
    bus.disponivelMul = 1;
    bus.instIn = 16'h0200; bus.instInValid = 1;
    cyc(1);
    bus.instIn = 16'h1232;
    cyc(1);
    bus.instInValid = 0;
    chk("t3_add", bus.Adderin, 1);
    cyc(1);
    chk("t3_mul", bus.Multin, 1);
    chk("t3_mul_instr", bus.instruction, 16'h1232);
    cyc(1);

    // fill to full, ninth push ignored, then drain in order across the wrap
    bus.disponivelAdd = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.instIn = 16'h1000 | 16'(i << 4); bus.instInValid = 1;
      cyc(1);
    end
    chk("t4_full_count", bus.count, 8);
    chk("t4_full_ready", bus.instInReady, 0);
    bus.instIn = 16'hFFF0;
    cyc(1);
    bus.instInValid = 0;
    chk("t4_ninth_ignored", bus.count, 8);
    bus.disponivelAdd = 1;
    for (int c = 0; c < 20; c++) begin
      cyc(1);
      if (bus.Adderin) got.push_back(bus.instruction);
    end
    chk("t4_issued_n", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      exp_w = 16'h1000 | 16'(i << 4);
      chk("t4_order", got[i], exp_w);
    end
    chk("t4_drained", bus.count, 0);

    // illegal, halt, then an add that must stay queued
    bus.instIn = 16'h0007; bus.instInValid = 1;
    cyc(1);
    bus.instIn = 16'h000F;
    cyc(1);
    chk("t5_illegal", bus.illegal, 1);
    bus.instIn = 16'h0C80;
    cyc(1);
    bus.instInValid = 0;
    chk("t5_illegal_once", bus.illegal, 0);
    chk("t5_halted", bus.halted, 1);
    cyc(4);
    chk("t5_count1", bus.count, 1);
    chk("t5_still_halted", bus.halted, 1);
    bus.flush = 1; bus.instIn = 16'h0C80; bus.instInValid = 1;
    cyc(1);
    bus.flush = 0; bus.instInValid = 0;
    chk("t5_flush_count", bus.count, 0);
    chk("t5_flush_halted", bus.halted, 0);
    chk("t5_flush_instr", bus.instruction, 16'h0000);
    cyc(2);
    chk("t5_push_dropped", bus.Adderin, 0);

    // stall counting with an add stuck at head
    bus.disponivelAdd = 0;
    bus.instIn = 16'h0C80; bus.instInValid = 1;
    cyc(1);
    bus.instInValid = 0;
    cyc(5);
`ifdef ISSUE_STATS_EN
    chk("t6_stall5", bus.stallCycles, 5);
`endif
    chk("t6_stalled_count", bus.count, 1);
    bus.disponivelAdd = 1;
    cyc(1);
    chk("t6_release", bus.Adderin, 1);
    cyc(2);

    // reset on the pop edge suppresses the strobe
    bus.instIn = 16'h0C80; bus.instInValid = 1;
    cyc(1);
    bus.instInValid = 0; Reset = 1;
    cyc(1);
    chk("t7_rst_adderin", bus.Adderin, 0);
    chk("t7_rst_count", bus.count, 0);
    Reset = 0;
    cyc(1);
    chk("t7_suppressed", bus.Adderin, 0);
    cyc(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- In-order instruction queue and issue stage that sits directly upstream of the adder reservation station, with a sibling port for the multiplier reservation station.
- Buffers 16-bit instructions from fetch in a circular FIFO and decodes the opcode of the head entry.
- Issues at most one instruction per cycle: adder-class to the adder RS via Adderin, multiplier-class via Multin.
- Issue is gated by the stations' disponivel flags. A halt opcode stops issue.

Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- PTR_W, 3: pointer width, log2(DEPTH).

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- instIn  in  16  instruction from fetch; [3:0] opcode, [12:10] Rz, [9:7] Rx, [6:4] Ry.
- instInValid  in  1  instIn is valid this cycle.
- instInReady  out  1  queue can accept; equals !full.
- flush  in  1  synchronous clear of queue contents and halt state.
- disponivelAdd  in  1  adder RS has a free entry.
- disponivelMul  in  1  multiplier RS has a free entry.
- instruction  out  16  issued instruction; shared by both stations.
- Adderin  out  1  one-cycle strobe: instruction is for the adder RS.
- Multin  out  1  one-cycle strobe: instruction is for the multiplier RS.
- count  out  PTR_W+1  number of occupied entries.
- halted  out  1  high while in state HALTED.
- illegal  out  1  one-cycle pulse when an undefined opcode is discarded.

Behaviour:
- Reset, flush or HALTED exit: rd_ptr = wr_ptr = 0, count = 0, state RUN, hold-offs cleared. Outputs: instruction = 0, Adderin = Multin = halted = illegal = 0, instInReady = 1.
- Opcode classes:
  - Adder: 0000 add, 0001 sub, 0100.
  - Multiplier: 0010, 0011.
  - Halt: 1111.
  - All others illegal.
- Push: when instInValid && instInReady, write to mem[wr_ptr] and increment wr_ptr (wraps modulo DEPTH). Push is accepted in any state; while HALTED, pushes keep filling the queue.
- Pop and push in the same cycle: count unchanged. Full means count == DEPTH; a pushed entry cannot be popped until the next cycle (no bypass).
- States: RUN, HALTED.
- RUN, head present (count > 0), decoded each cycle:
  - Adder class, disponivelAdd = 1, add_holdoff = 0: pop. Next cycle instruction = head, Adderin = 1, and add_holdoff is set for one cycle.
  - Multiplier class: same rule with disponivelMul, Multin and mul_holdoff.
  - Unit unavailable or in hold-off: stall. No pop, strobes = 0, instruction holds its last value.
  - Illegal: pop, no strobe, illegal pulses the next cycle.
  - Halt: pop, go to HALTED, halted = 1 from the next cycle.
- Hold-off: disponivel is derived from RS Busy bits, so it reflects the previous issue only one cycle late. Issuing back-to-back to the same unit is therefore forbidden. Maximum rate is one issue per unit every 2 cycles. An adder issue and a multiplier issue may occur on consecutive cycles.
- Strobes are registered and last exactly one cycle. Adderin and Multin are never high together.
- Empty in RUN: no pop, strobes = 0.
- HALTED: no issue. Leave only on Reset or flush, both of which discard the queue contents.
- flush and push in the same cycle: flush wins; the push is dropped.
- Reset mid-issue: a strobe due on the following cycle is suppressed.

Optional Feature:
- Macro ISSUE_STATS_EN.
- Defined: adds output stallCycles [15:0]. It increments, saturating at 16'hFFFF, on each RUN cycle where count > 0 and the head is not popped. Cleared by Reset or flush.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then push 16'h0C80 (add, opcode 0000), disponivelAdd = 1 -> Adderin = 1 and instruction = 16'h0C80 two cycles after the push; count returns to 0.
- Push two adds back-to-back, disponivelAdd held at 1 -> Adderin pulses on cycles N and N+2, never on N+1.
- Push an add then a multiply (opcode 0010), both stations available -> Adderin on cycle N, Multin on cycle N+1.
- Fill 8 entries with disponivelAdd = 0 -> instInReady = 0, count = 8, a ninth push is ignored. Raise disponivelAdd -> pointers wrap and all 8 instructions issue in order.
- Push opcode 0111, then 1111, then an add -> illegal pulses once, then halted = 1, the add never issues and count = 1. Assert flush -> count = 0, halted = 0.
- With ISSUE_STATS_EN, hold disponivelAdd = 0 for 5 cycles with an add at head -> stallCycles = 5.
